data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised RV32IM data memory with byte/halfword/word access, load sign/zero extension, access-fault detection and a configurable wait-state handshake that stalls the pipeline. It sits in the MEM stage, driven by the ALU result (address), rs2 (store data) and the instruction's funct3. Its `stall` output freezes the pipeline while an access is in flight, so the same pipeline works with zero-wait SRAM and with slower memories.

## Interface
- `MEM_DEPTH`, 1024: number of 32-bit words; power of two, ≥ 4.
- `WAIT_CYCLES`, 2: extra cycles per access; 0..15; 0 means single-cycle.

- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 32: byte address.
- `writeData` in 32: store data; the low bytes are used for SB/SH.
- `funct3` in 3: access size/sign. 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `memRead` in 1: load request.
- `memWrite` in 1: store request.
- `readData` out 32: extended load result; valid only while `done`=1, otherwise 0.
- `stall` out 1: combinational; 1 = hold the pipeline.
- `done` out 1: combinational; 1 in the completion cycle of a legal access.
- `accessFault` out 1: combinational; 1 in the cycle an illegal request is presented in IDLE.

## Operation
- Request = `memRead | memWrite`, sampled only in IDLE.
- Illegal request raises `accessFault`, causes no state change, no write, `readData`=0 and `stall`=0. A request is illegal if:
  - `memRead` and `memWrite` are both 1;
  - funct3 is undefined for the op (loads: 011/110/111; stores: anything other than 000/001/010);
  - H/HU with `address[0]`=1, or W with `address[1:0]`≠0;
  - `address` ≥ 4·MEM_DEPTH.
- Word index is `address[log2(MEM_DEPTH)+1:2]`. Byte lane is `address[1:0]`. Little-endian.
- Stores:
  - SB writes `writeData[7:0]` to the addressed lane only.
  - SH writes `writeData[15:0]` to lanes {1,0} or {3,2}.
  - SW writes all 4 lanes.
  - Untouched lanes are preserved.
- Loads:
  - B/H are sign-extended from bit 7/15; BU/HU are zero-extended.
  - W returns the word unchanged.
- FSM states are IDLE and WAIT. Counter `cnt` is 4 bits.
  - IDLE, legal request, WAIT_CYCLES=0: complete in the same cycle (`done`=1, `stall`=0). A store commits at this edge. Stay in IDLE.
  - IDLE, legal request, WAIT_CYCLES>0: latch address, writeData, funct3 and op. Set `cnt`←WAIT_CYCLES−1, go to WAIT, `stall`=1.
  - WAIT, `cnt`≠0: `stall`=1, `cnt`←`cnt`−1.
  - WAIT, `cnt`=0: `stall`=0, `done`=1. `readData` comes from the latched request. A latched store commits at this edge. Go to IDLE.
- In WAIT, input changes are ignored; the latched copy is authoritative.
- Reset is synchronous with these effects:
  - State goes to IDLE and `cnt` goes to 0.
  - Latched request is cleared, and a store in flight is discarded.
  - Memory contents are not initialised.
- Reset outputs are `stall`=0, `done`=0, `accessFault`=0 and `readData`=0.

## Timing
- With WAIT_CYCLES=N, a legal access holds `stall` high for exactly N cycles. The first of these is the cycle the request appears in IDLE. Completion is cycle N.
- The store becomes visible to a load accepted in the next cycle (read-after-write, back-to-back).
- A new request can be accepted in the cycle immediately after `done`, giving a throughput of 1 access per N+1 cycles.
- `reset` asserted in WAIT: the next cycle is IDLE, no write occurs, and `done` is never raised for the aborted access.
- `reset` has priority over any request in the same cycle.

## Test plan
- N=0, SW 0xDEADBEEF @0x10, then LW @0x10 → `stall` never high; `readData`=0xDEADBEEF with `done`=1 in the load cycle.
- N=2, SB 0x80 @0x13 over the word 0x11223344 @0x10:
  - `stall`=1 for 2 cycles, then `done`.
  - LB @0x13 → 0xFFFFFF80; LBU → 0x00000080; LW → 0x80223344.
- N=2, SH 0x8001 @0x12, then LH @0x12 → 0xFFFF8001 and LHU → 0x00008001. LH @0x11 → `accessFault`=1, `stall`=0, and memory unchanged.
- N=3, SW accepted, `address`/`writeData` changed during WAIT, then LW to the original address → the original data is read; the new address is untouched.
- N=3, `reset` pulsed in the second stall cycle of SW 0xCAFEF00D @0x20:
  - FSM returns to IDLE and `done` is never raised for the aborted store.
  - Word @0x20 keeps its prior value.
- Address 4·MEM_DEPTH, and `memRead`=`memWrite`=1 @0x0 → each raises `accessFault` for one cycle, with no write and no stall.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
// MEM-stage data memory for an RV32IM pipeline. It handles byte, halfword
// and word loads and stores, with sign or zero extension on loads. It
// detects access faults and inserts a configurable number of wait states,
// raising stall while an access is in flight.
//
// Parameters
//   MEM_DEPTH    number of 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  extra cycles per access (0..15, 0 = single cycle)
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   address      byte address of the access
//   writeData    store data (low bytes used for SB/SH)
//   funct3       access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   memRead      load request
//   memWrite     store request
//   readData     extended load result, non-zero only while done=1
//   stall        hold the pipeline (combinational)
//   done         completion cycle of a legal access (combinational)
//   accessFault  illegal request presented in IDLE (combinational)
module data_memory_ctrl #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic [2:0]  funct3,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] readData,
  output logic        stall,
  output logic        done,
  output logic        accessFault
);

  localparam int          AW        = $clog2(MEM_DEPTH);
  localparam logic [32:0] LIMIT     = 33'(4 * MEM_DEPTH);
  localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CNT_INIT  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;

  // Copy of the accepted request; authoritative while in WAIT
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [2:0]    r_f3;
  logic          r_wr;

  logic [31:0] r_mem [MEM_DEPTH];

  // ---------------- request decode (meaningful in IDLE only) ----------------
  logic w_req;
  logic w_ld_ok;
  logic w_st_ok;
  logic w_align_ok;
  logic w_range_ok;
  logic w_legal;

  assign w_req      = memRead | memWrite;
  assign w_ld_ok    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_st_ok    = funct3 inside {3'b000, 3'b001, 3'b010};
  assign w_range_ok = ({1'b0, address} < LIMIT);

  always_comb begin
    w_align_ok = 1'b1;
    case (funct3[1:0])
      2'b01:   w_align_ok = ~address[0];
      2'b10:   w_align_ok = (address[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
  end

  assign w_legal = ~(memRead & memWrite) &&
                   (memRead ? w_ld_ok : w_st_ok) &&
                   w_align_ok && w_range_ok;

  // ---------------- effective request: live in IDLE, latched in WAIT ----------------
  logic          w_in_wait;
  logic [AW+1:0] w_addr;
  logic [31:0]   w_wdata;
  logic [2:0]    w_f3;
  logic          w_is_write;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;

  assign w_in_wait  = (r_state == S_WAIT);
  assign w_addr     = w_in_wait ? r_addr  : address[AW+1:0];
  assign w_wdata    = w_in_wait ? r_wdata : writeData;
  assign w_f3       = w_in_wait ? r_f3    : funct3;
  assign w_is_write = w_in_wait ? r_wr    : memWrite;
  assign w_idx      = w_addr[AW+1:2];
  assign w_lane     = w_addr[1:0];

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_f3    <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && w_req && w_legal) begin
        r_addr  <= address[AW+1:0];
        r_wdata <= writeData;
        r_f3    <= funct3;
        r_wr    <= memWrite;
      end
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req && w_legal && !ZERO_WAIT) begin
          w_state_next = S_WAIT;
          w_cnt_next   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------- load path ----------------
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_lane, 3'b000} +: 8];
  assign w_half = w_word[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = w_word;
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
  end

  // ---------------- outputs ----------------
  // Reset masks every output so a request in the reset cycle has no effect.
  always_comb begin
    stall       = 1'b0;
    done        = 1'b0;
    accessFault = 1'b0;
    readData    = 32'd0;
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (!w_legal)      accessFault = 1'b1;
            else if (ZERO_WAIT) done       = 1'b1;
            else                stall      = 1'b1;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) stall = 1'b1;
          else               done  = 1'b1;
        end
        default: ;
      endcase
    end
    if (done && !w_is_write) readData = w_load;
  end

  // ---------------- store path ----------------
  logic [3:0]  w_be;
  logic [31:0] w_wd;
  logic        w_we;

  always_comb begin
    w_be = 4'hF;
    w_wd = w_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_lane;
        w_wd = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be = 4'hF;
        w_wd = w_wdata;
      end
    endcase
  end

  // A store commits on the edge that ends its done cycle.
  assign w_we = done & w_is_write;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wd[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
module tb_data_memory_ctrl;

  localparam int DEPTH = 64;
  localparam int BYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] t_addr  [3];
  logic [31:0] t_wdata [3];
  logic [2:0]  t_f3    [3];
  logic        t_rd    [3];
  logic        t_wr    [3];
  logic [31:0] w_rdata [3];
  logic        w_stall [3];
  logic        w_done  [3];
  logic        w_fault [3];

  always #5 clk = ~clk;

  // Instance 0: no wait states, 1: two, 2: three
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    data_memory_ctrl #(
      .MEM_DEPTH  (DEPTH),
      .WAIT_CYCLES(gi == 0 ? 0 : gi + 1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .address    (t_addr[gi]),
      .writeData  (t_wdata[gi]),
      .funct3     (t_f3[gi]),
      .memRead    (t_rd[gi]),
      .memWrite   (t_wr[gi]),
      .readData   (w_rdata[gi]),
      .stall      (w_stall[gi]),
      .done       (w_done[gi]),
      .accessFault(w_fault[gi])
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference byte-addressed memory per instance
  logic [7:0] mm [3][BYTES];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h", name, k, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 0;
    if (!rd && !wr) return 0;
    if (a >= BYTES) return 0;
    if (wr && f3 > 3'd2) return 0;
    if (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 0;
    if (a % nbytes(f3) != 0) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input int k, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int n;
    n = nbytes(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[k][a + i]) << (8 * i));
    if (!f3[2] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < nbytes(f3); i++) mm[k][a + i] = wd[8*i +: 8];
  endtask

  task automatic idle_inputs(input int k);
    t_rd[k] = 1'b0; t_wr[k] = 1'b0; t_addr[k] = 0; t_wdata[k] = 0; t_f3[k] = 0;
  endtask

  // Presents one request (called just after a rising edge) and checks every
  // cycle until it completes or faults. With scr set, the inputs are replaced
  // by garbage (address ga) while the access is in flight.
  task automatic access(input int k, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit scr,
                        input logic [31:0] ga, output logic [31:0] got, output logic gotf);
    int n;
    bit lg;
    logic [31:0] ex;
    n  = (k == 0) ? 0 : k + 1;
    lg = is_legal(rd, wr, f3, a);
    ex = (lg && rd) ? model_load(k, f3, a) : 32'd0;
    $display("xact dut=%0d rd=%0b wr=%0b f3=%0d addr=%h wd=%h legal=%0b exp=%h", k, rd, wr, f3, a, wd, lg, ex);
    t_rd[k] = rd; t_wr[k] = wr; t_f3[k] = f3; t_addr[k] = a; t_wdata[k] = wd;
    got = 0; gotf = 0;
    if (!lg) begin
      @(negedge clk);
      gotf = w_fault[k];
      chk("fault", k, 32'(w_fault[k]), 1);
      chk("fault_stall", k, 32'(w_stall[k]), 0);
      chk("fault_done", k, 32'(w_done[k]), 0);
      chk("fault_rdata", k, w_rdata[k], 0);
      @(posedge clk); #1;
    end else begin
      for (int c = 0; c <= n; c++) begin
        @(negedge clk);
        chk("stall", k, 32'(w_stall[k]), 32'(c < n));
        chk("done", k, 32'(w_done[k]), 32'(c == n));
        chk("nofault", k, 32'(w_fault[k]), 0);
        if (rd) chk("rdata", k, w_rdata[k], (c == n) ? ex : 32'd0);
        if (c == n) got = w_rdata[k];
        @(posedge clk); #1;
        if (scr && c < n) begin
          t_addr[k] = ga; t_wdata[k] = $urandom; t_f3[k] = 3'($urandom);
          t_rd[k] = 1'($urandom); t_wr[k] = 1'($urandom);
        end
      end
      if (wr) model_store(k, f3, a, wd);
    end
    idle_inputs(k);
  endtask

  typedef struct {
    int          k;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ef;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int k, input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input logic ef, input logic [31:0] ed);
    vec_t v;
    v.k = k; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.ef = ef; v.ed = ed;
    tbl.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog dut=all got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    logic        gotf;

    // ---------------- reset, with a request present on instance 1 ----------------
    reset = 1'b1;
    for (int k = 0; k < 3; k++) idle_inputs(k);
    t_wr[1] = 1'b1; t_f3[1] = 3'd2; t_addr[1] = 32'h4; t_wdata[1] = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", k, 32'(w_stall[k]), 0);
      chk("rst_done",  k, 32'(w_done[k]), 0);
      chk("rst_fault", k, 32'(w_fault[k]), 0);
      chk("rst_rdata", k, w_rdata[k], 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs(1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) chk("idle_stall", k, 32'(w_stall[k]), 0);
    @(posedge clk); #1;

    // ---------------- directed vector table ----------------
    add(0, 0, 1, 3'b010, 32'h10,  32'hDEAD_BEEF, 0, 0);
    add(0, 1, 0, 3'b010, 32'h10,  0,             0, 32'hDEAD_BEEF);
    add(0, 1, 0, 3'b010, 32'h100, 0,             1, 0);
    add(0, 1, 1, 3'b010, 32'h0,   32'h5,         1, 0);
    add(1, 0, 1, 3'b010, 32'h10,  32'h1122_3344, 0, 0);
    add(1, 0, 1, 3'b000, 32'h13,  32'h0000_0080, 0, 0);
    add(1, 1, 0, 3'b000, 32'h13,  0,             0, 32'hFFFF_FF80);
    add(1, 1, 0, 3'b100, 32'h13,  0,             0, 32'h0000_0080);
    add(1, 1, 0, 3'b010, 32'h10,  0,             0, 32'h8022_3344);
    add(1, 0, 1, 3'b001, 32'h12,  32'hAAAA_8001, 0, 0);
    add(1, 1, 0, 3'b001, 32'h12,  0,             0, 32'hFFFF_8001);
    add(1, 1, 0, 3'b101, 32'h12,  0,             0, 32'h0000_8001);
    add(1, 1, 0, 3'b001, 32'h11,  0,             1, 0);
    add(1, 0, 1, 3'b010, 32'h12,  32'h0BAD_0BAD, 1, 0);
    add(1, 0, 1, 3'b011, 32'h10,  32'h0BAD_0BAD, 1, 0);
    add(1, 1, 0, 3'b110, 32'h10,  0,             1, 0);
    add(1, 1, 0, 3'b010, 32'h10,  0,             0, 32'h8001_3344);
    add(1, 0, 1, 3'b010, 32'h100, 32'h0BAD_0BAD, 1, 0);
    add(1, 1, 1, 3'b010, 32'h0,   32'h0BAD_0BAD, 1, 0);
    add(2, 1, 0, 3'b000, 32'h101, 0,             1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      access(tbl[i].k, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, 0, 0, got, gotf);
      if (tbl[i].ef) chk("tbl_fault", tbl[i].k, 32'(gotf), 1);
      else if (tbl[i].rd) chk("tbl_data", tbl[i].k, got, tbl[i].ed);
    end

    // ---------------- inputs changed during WAIT are ignored ----------------
    access(2, 0, 1, 3'b010, 32'h40, 32'h0102_0304, 0, 0, got, gotf);
    access(2, 0, 1, 3'b010, 32'h30, 32'h5555_AAAA, 1, 32'h40, got, gotf);
    access(2, 1, 0, 3'b010, 32'h30, 0, 0, 0, got, gotf);
    chk("latch_orig", 2, got, 32'h5555_AAAA);
    access(2, 1, 0, 3'b010, 32'h40, 0, 0, 0, got, gotf);
    chk("latch_other", 2, got, 32'h0102_0304);

    // ---------------- reset in the second stall cycle of a store ----------------
    access(2, 0, 1, 3'b010, 32'h20, 32'h1234_5678, 0, 0, got, gotf);
    $display("xact dut=2 reset-abort SW addr=00000020 wd=cafef00d");
    t_wr[2] = 1'b1; t_f3[2] = 3'b010; t_addr[2] = 32'h20; t_wdata[2] = 32'hCAFE_F00D;
    @(negedge clk);
    chk("abort_stall0", 2, 32'(w_stall[2]), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_stall", 2, 32'(w_stall[2]), 0);
    chk("abort_rst_done", 2, 32'(w_done[2]), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs(2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_done", 2, 32'(w_done[2]), 0);
      chk("abort_stall", 2, 32'(w_stall[2]), 0);
      @(posedge clk); #1;
    end
    access(2, 1, 0, 3'b010, 32'h20, 0, 0, 0, got, gotf);
    chk("abort_keep", 2, got, 32'h1234_5678);

    // ---------------- fill memory, then randomized traffic ----------------
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < DEPTH; w++)
        access(k, 0, 1, 3'b010, 32'(4 * w), $urandom, 0, 0, got, gotf);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 200; i++) begin
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a;
        int          op, r;
        op = $urandom_range(0, 9);
        rd = (op <= 5);
        wr = (op == 0) || (op >= 6);
        f3 = 3'($urandom_range(0, 7));
        r  = $urandom_range(0, 9);
        if (r == 0) a = BYTES + $urandom_range(0, 4000);
        else a = 32'($urandom_range(0, BYTES - 1));
        if (r >= 1 && r < 7) a = a & ~32'(nbytes(f3) - 1);
        access(k, rd, wr, f3, a, $urandom, 1, $urandom_range(0, BYTES - 1), got, gotf);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
